chat_line_editor: RTL and testbench



---
 rtl/chat_line_editor.sv | 162 ++++++++++++++++
 tb/tb_chat_line_editor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chat_line_editor.sv
// chat_line_editor: turns PS/2 set-2 scan-code bytes into an editable line of
// character indices (0..25 = A..Z, 26 = space), then hands the line to the
// transmit side with a msg_ready/msg_ack handshake.
// Optional build macro: TYPEMATIC_FILTER_EN (drops repeated make codes
// until a break sequence is seen).

// Set-2 make code to letter index decoder.
module scancode_to_index (
  input  logic [7:0] scan,
  output logic       is_letter,
  output logic [4:0] char_index
);
  // Pure lookup; non-letters report is_letter=0 with index 0.
  always_comb begin
    is_letter  = 1'b1;
    char_index = 5'd0;
    case (scan)
      8'h1C: char_index = 5'd0;   8'h32: char_index = 5'd1;
      8'h21: char_index = 5'd2;   8'h23: char_index = 5'd3;
      8'h24: char_index = 5'd4;   8'h2B: char_index = 5'd5;
      8'h34: char_index = 5'd6;   8'h33: char_index = 5'd7;
      8'h43: char_index = 5'd8;   8'h3B: char_index = 5'd9;
      8'h42: char_index = 5'd10;  8'h4B: char_index = 5'd11;
      8'h3A: char_index = 5'd12;  8'h31: char_index = 5'd13;
      8'h44: char_index = 5'd14;  8'h4D: char_index = 5'd15;
      8'h15: char_index = 5'd16;  8'h2D: char_index = 5'd17;
      8'h1B: char_index = 5'd18;  8'h2C: char_index = 5'd19;
      8'h3C: char_index = 5'd20;  8'h2A: char_index = 5'd21;
      8'h1D: char_index = 5'd22;  8'h22: char_index = 5'd23;
      8'h35: char_index = 5'd24;  8'h1A: char_index = 5'd25;
      default: is_letter = 1'b0;
    endcase
  end
endmodule

module chat_line_editor #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN+1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       kb_valid,
  input  logic [7:0]                 kb_byte,
  input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
  output logic [4:0]                 rd_data,
  output logic [LEN_W-1:0]           line_len,
  output logic                       msg_ready,
  input  logic                       msg_ack,
  output logic                       key_echo,
  output logic [4:0]                 key_echo_idx,
  output logic                       overflow
);
  localparam int AW = $clog2(MAX_LEN);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t     state_q, state_d;
  logic       is_make, brk_done;
  logic       is_letter, is_space, is_char;
  logic [4:0] char_index, char_code;
  logic       do_make, full, append, drop, bksp, commit, ack;
  logic [4:0] line_buf [MAX_LEN];

  scancode_to_index u_dec (
    .scan       (kb_byte),
    .is_letter  (is_letter),
    .char_index (char_index)
  );

  // Prefix tracker state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Prefix next-state; flags plain make codes and completed break sequences.
  always_comb begin
    state_d  = state_q;
    is_make  = 1'b0;
    brk_done = 1'b0;
    if (kb_valid) begin
      case (state_q)
        IDLE: begin
          if      (kb_byte == 8'hE0) state_d = EXT;
          else if (kb_byte == 8'hF0) state_d = BRK;
          else                       is_make = 1'b1;
        end
        BRK: begin
          state_d  = IDLE;
          brk_done = 1'b1;
        end
        EXT: state_d = (kb_byte == 8'hF0) ? EXT_BRK : IDLE;
        EXT_BRK: begin
          state_d  = IDLE;
          brk_done = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef TYPEMATIC_FILTER_EN
  logic [7:0] last_make;

  // Remember the last make code; a completed break re-arms the filter.
  always_ff @(posedge clk) begin
    if (rst)           last_make <= 8'h00;
    else if (brk_done) last_make <= 8'h00;
    else if (is_make)  last_make <= kb_byte;
  end

  assign do_make = is_make && !msg_ready && (kb_byte != last_make);
`else
  assign do_make = is_make && !msg_ready;
`endif

  // Make-code decode; msg_ready doubles as the lock, so a make code landing
  // in the ack cycle is discarded as well.
  always_comb begin
    is_space  = (kb_byte == 8'h29);
    is_char   = is_letter || is_space;
    char_code = is_space ? 5'd26 : char_index;
    full      = (line_len == LEN_W'(MAX_LEN));
    append    = do_make && is_char && !full;
    drop      = do_make && is_char && full;
    bksp      = do_make && (kb_byte == 8'h66) && (line_len != '0);
    commit    = do_make && (kb_byte == 8'h5A) && (line_len != '0);
    ack       = msg_ack && msg_ready;
  end

  // Line state, lock handshake and echo pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_len     <= '0;
      msg_ready    <= 1'b0;
      key_echo     <= 1'b0;
      key_echo_idx <= 5'd0;
      overflow     <= 1'b0;
    end else begin
      key_echo <= append;
      if (append) key_echo_idx <= char_code;
      if (ack) begin
        line_len  <= '0;
        msg_ready <= 1'b0;
        overflow  <= 1'b0;
      end else begin
        if (append) line_len  <= line_len + LEN_W'(1);
        if (bksp)   line_len  <= line_len - LEN_W'(1);
        if (drop)   overflow  <= 1'b1;
        if (commit) msg_ready <= 1'b1;
      end
    end
  end

  // Character storage; contents need no reset since line_len gates validity.
  always_ff @(posedge clk) begin
    if (append) line_buf[line_len[AW-1:0]] <= char_code;
  end

  assign rd_data = line_buf[rd_addr];

endmodule

// File: tb/tb_chat_line_editor.sv
// Self-checking bench for chat_line_editor: vector tables of bytes with the
// expected registered outputs one cycle later, checked through a scoreboard.
module tb_chat_line_editor;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = $clog2(MAX_LEN+1);

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       kb_valid = 1'b0;
  logic [7:0]                 kb_byte = 8'h00;
  logic [$clog2(MAX_LEN)-1:0] rd_addr = '0;
  logic [4:0]                 rd_data;
  logic [LEN_W-1:0]           line_len;
  logic                       msg_ready;
  logic                       msg_ack = 1'b0;
  logic                       key_echo;
  logic [4:0]                 key_echo_idx;
  logic                       overflow;

  chat_line_editor #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .kb_valid(kb_valid), .kb_byte(kb_byte),
    .rd_addr(rd_addr), .rd_data(rd_data), .line_len(line_len),
    .msg_ready(msg_ready), .msg_ack(msg_ack), .key_echo(key_echo),
    .key_echo_idx(key_echo_idx), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] b;
    logic       ack;
    int         len;
    logic       rdy;
    logic       echo;
    logic [4:0] idx;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   step_no = 0;
  logic [7:0] letter_sc [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,
    8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,
    8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};

  function automatic vec_t mk(logic v, logic [7:0] b, logic ack, int len,
                              logic rdy, logic echo, logic [4:0] idx, logic ovf);
    vec_t r;
    r.v = v; r.b = b; r.ack = ack; r.len = len; r.rdy = rdy;
    r.echo = echo; r.idx = idx; r.ovf = ovf;
    return r;
  endfunction

  // Shorthand: a key byte with no ack, nothing committed, no overflow.
  function automatic vec_t kb(logic [7:0] b, int len, logic echo, logic [4:0] idx);
    return mk(1'b1, b, 1'b0, len, 1'b0, echo, idx, 1'b0);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0d expected=%0d", name, step_no, act, exp);
    end
  endtask

  task automatic check_pending();
    vec_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("line_len", int'(line_len), e.len);
      chk("msg_ready", int'(msg_ready), int'(e.rdy));
      chk("key_echo", int'(key_echo), int'(e.echo));
      if (e.echo) chk("key_echo_idx", int'(key_echo_idx), int'(e.idx));
      chk("overflow", int'(overflow), int'(e.ovf));
      step_no++;
    end
  endtask

  // Drive at the falling edge so consecutive steps give back-to-back kb_valid.
  task automatic step(input vec_t v);
    @(negedge clk);
    check_pending();
    kb_valid = v.v; kb_byte = v.b; msg_ack = v.ack;
    sb.push_back(v);
  endtask

  task automatic flush();
    @(negedge clk);
    check_pending();
    kb_valid = 1'b0; msg_ack = 1'b0;
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) step(tbl[i]);
    flush();
    tbl.delete();
  endtask

  task automatic chk_rd(input int addr, input int exp);
    rd_addr = addr[$clog2(MAX_LEN)-1:0];
    #1;
    chk("rd_data", int'(rd_data), exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; kb_valid = 1'b0; msg_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_len", int'(line_len), 0);
    chk("rst_ready", int'(msg_ready), 0);
    chk("rst_echo", int'(key_echo), 0);
    chk("rst_idx", int'(key_echo_idx), 0);
    chk("rst_ovf", int'(overflow), 0);
  endtask

  initial begin
    do_reset();

    // H, E
    tbl.push_back(kb(8'h33, 1, 1, 7));
    tbl.push_back(kb(8'hF0, 1, 0, 0));
    tbl.push_back(kb(8'h33, 1, 0, 0));
    tbl.push_back(kb(8'h24, 2, 1, 4));
    tbl.push_back(kb(8'hF0, 2, 0, 0));
    tbl.push_back(kb(8'h24, 2, 0, 0));
    run_tbl();
    chk_rd(0, 7);
    chk_rd(1, 4);

    // Backspace down to empty, then once more at zero.
    tbl.push_back(kb(8'h66, 1, 0, 0));
    tbl.push_back(kb(8'hF0, 1, 0, 0));
    tbl.push_back(kb(8'h66, 1, 0, 0));
    tbl.push_back(kb(8'h66, 0, 0, 0));
    tbl.push_back(kb(8'hF0, 0, 0, 0));
    tbl.push_back(kb(8'h66, 0, 0, 0));
    tbl.push_back(kb(8'h66, 0, 0, 0));
    tbl.push_back(kb(8'hF0, 0, 0, 0));
    tbl.push_back(kb(8'h66, 0, 0, 0));
    // A, space, backspace
    tbl.push_back(kb(8'h1C, 1, 1, 0));
    tbl.push_back(kb(8'hF0, 1, 0, 0));
    tbl.push_back(kb(8'h1C, 1, 0, 0));
    tbl.push_back(kb(8'h29, 2, 1, 26));
    tbl.push_back(kb(8'hF0, 2, 0, 0));
    tbl.push_back(kb(8'h29, 2, 0, 0));
    tbl.push_back(kb(8'h66, 1, 0, 0));
    tbl.push_back(kb(8'hF0, 1, 0, 0));
    tbl.push_back(kb(8'h66, 1, 0, 0));
    run_tbl();
    chk_rd(0, 0);
    chk_rd(1, 26);

    // Clear, Enter on empty line, extended keys ignored, then plain A.
    tbl.push_back(kb(8'h66, 0, 0, 0));
    tbl.push_back(kb(8'hF0, 0, 0, 0));
    tbl.push_back(kb(8'h66, 0, 0, 0));
    tbl.push_back(kb(8'h5A, 0, 0, 0));
    tbl.push_back(kb(8'hF0, 0, 0, 0));
    tbl.push_back(kb(8'h5A, 0, 0, 0));
    tbl.push_back(kb(8'hE0, 0, 0, 0));
    tbl.push_back(kb(8'h1C, 0, 0, 0));
    tbl.push_back(kb(8'hE0, 0, 0, 0));
    tbl.push_back(kb(8'hF0, 0, 0, 0));
    tbl.push_back(kb(8'h1C, 0, 0, 0));
    tbl.push_back(kb(8'h1C, 1, 1, 0));
    tbl.push_back(kb(8'hF0, 1, 0, 0));
    tbl.push_back(kb(8'h1C, 1, 0, 0));
    // B, C, commit with three chars, then keys while locked.
    tbl.push_back(kb(8'h32, 2, 1, 1));
    tbl.push_back(kb(8'hF0, 2, 0, 0));
    tbl.push_back(kb(8'h32, 2, 0, 0));
    tbl.push_back(kb(8'h21, 3, 1, 2));
    tbl.push_back(kb(8'hF0, 3, 0, 0));
    tbl.push_back(kb(8'h21, 3, 0, 0));
    tbl.push_back(mk(1, 8'h5A, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'hF0, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h5A, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h1C, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h66, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h22, 0, 3, 1, 0, 0, 0));
    run_tbl();
    chk_rd(2, 2);
    // Make code in the ack cycle is discarded.
    tbl.push_back(mk(1, 8'h1C, 1, 0, 0, 0, 0, 0));
    tbl.push_back(kb(8'hF0, 0, 0, 0));
    tbl.push_back(kb(8'h1C, 0, 0, 0));
    // Ack while unlocked does nothing.
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0));
    run_tbl();

    // Fill to MAX_LEN, overflow, commit, ack.
    for (int i = 0; i < MAX_LEN; i++)
      tbl.push_back(kb(letter_sc[i % 26], i + 1, 1, 5'(i % 26)));
    tbl.push_back(mk(1, 8'h1A, 0, MAX_LEN, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'h5A, 0, MAX_LEN, 1, 0, 0, 1));
    tbl.push_back(mk(1, 8'hF0, 0, MAX_LEN, 1, 0, 0, 1));
    tbl.push_back(mk(1, 8'h5A, 0, MAX_LEN, 1, 0, 0, 1));
    run_tbl();
    chk_rd(MAX_LEN - 1, (MAX_LEN - 1) % 26);
    chk_rd(25, 25);
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0));
    tbl.push_back(kb(8'h3A, 1, 1, 12));
    run_tbl();

    // Reset mid-sequence drops the pending E0 prefix.
    tbl.push_back(kb(8'hF0, 1, 0, 0));
    tbl.push_back(kb(8'h3A, 1, 0, 0));
    tbl.push_back(kb(8'hE0, 1, 0, 0));
    run_tbl();
    do_reset();
    tbl.push_back(kb(8'h1C, 1, 1, 0));
    tbl.push_back(kb(8'hF0, 1, 0, 0));
    tbl.push_back(kb(8'h1C, 1, 0, 0));
    run_tbl();

    // Auto-repeat handling.
    do_reset();
`ifdef TYPEMATIC_FILTER_EN
    tbl.push_back(kb(8'h1C, 1, 1, 0));
    tbl.push_back(kb(8'h1C, 1, 0, 0));
    tbl.push_back(kb(8'h1C, 1, 0, 0));
    tbl.push_back(kb(8'hF0, 1, 0, 0));
    tbl.push_back(kb(8'h1C, 1, 0, 0));
    tbl.push_back(kb(8'h1C, 2, 1, 0));
`else
    tbl.push_back(kb(8'h1C, 1, 1, 0));
    tbl.push_back(kb(8'h1C, 2, 1, 0));
    tbl.push_back(kb(8'h1C, 3, 1, 0));
    tbl.push_back(kb(8'hF0, 3, 0, 0));
    tbl.push_back(kb(8'h1C, 3, 0, 0));
    tbl.push_back(kb(8'h1C, 4, 1, 0));
`endif
    run_tbl();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
